// File: rtl/stack_pkg.sv
// Shared constants, FSM encoding and requester IDs for the stack controller.
package stack_pkg;

   localparam int unsigned STACK_BASE  = 512;
   localparam int unsigned STACK_DEPTH = 64;
   localparam int unsigned WORD_BYTES  = 4;
   localparam int unsigned DATA_W      = 32;

   localparam logic [DATA_W-1:0] SP_EMPTY = DATA_W'(STACK_BASE);
   localparam logic [DATA_W-1:0] SP_FULL  = DATA_W'(STACK_BASE + WORD_BYTES * STACK_DEPTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MEM  = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic REQ_A = 1'b0;
   localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; the pointer moves past whichever requester was granted.
module rr_arb2
   import stack_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic req_a,
   input  logic req_b,
   input  logic take,
   output logic gnt_idx_c,
   output logic gnt_valid_c
);

   logic ptr;

   // A lone requester wins outright; a tie goes to the pointed requester.
   always_comb begin
      gnt_valid_c = req_a | req_b;
      gnt_idx_c   = REQ_A;
      if (req_a && req_b)
         gnt_idx_c = ptr;
      else if (req_b)
         gnt_idx_c = REQ_B;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         ptr <= REQ_A;
      else if (take && gnt_valid_c)
         ptr <= ~gnt_idx_c;
   end

endmodule

// File: rtl/stack_ctrl.sv
// Bounds-checked stack controller: arbitrates two requesters and sequences
// one data-memory access per push/pop, owning SP and the full/empty flags.
module stack_ctrl
   import stack_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        a_valid,
   input  logic        a_push,
   input  logic [31:0] a_wdata,
   output logic        a_done,
   input  logic        b_valid,
   input  logic        b_push,
   input  logic [31:0] b_wdata,
   output logic        b_done,
   output logic [31:0] rdata,
   output logic        err,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_we,
   output logic        mem_re,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic [31:0] sp_out,
   output logic        full,
   output logic        empty
);

   state_t      state;
   logic        req_id;
   logic        req_push;
   logic        gnt_idx_c;
   logic        gnt_valid_c;
   logic        take_c;
   logic        sel_push_c;
   logic [31:0] sel_wdata_c;
   logic        illegal_c;
   logic [31:0] sp_inc_c;
   logic [31:0] sp_dec_c;

   assign take_c = (state == IDLE);

   rr_arb2 u_arb (
      .clk         (clk),
      .rst         (rst),
      .req_a       (a_valid),
      .req_b       (b_valid),
      .take        (take_c),
      .gnt_idx_c   (gnt_idx_c),
      .gnt_valid_c (gnt_valid_c)
   );

   // Granted request and its bounds check against the current SP.
   always_comb begin
      sel_push_c  = (gnt_idx_c == REQ_B) ? b_push  : a_push;
      sel_wdata_c = (gnt_idx_c == REQ_B) ? b_wdata : a_wdata;
      sp_inc_c    = sp_out + 32'(WORD_BYTES);
      sp_dec_c    = sp_out - 32'(WORD_BYTES);
      illegal_c   = sel_push_c ? (sp_out == SP_FULL) : (sp_out == SP_EMPTY);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         req_id    <= REQ_A;
         req_push  <= 1'b0;
         sp_out    <= SP_EMPTY;
         full      <= 1'b0;
         empty     <= 1'b1;
         a_done    <= 1'b0;
         b_done    <= 1'b0;
         err       <= 1'b0;
         rdata     <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_we    <= 1'b0;
         mem_re    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (gnt_valid_c) begin
                  req_id   <= gnt_idx_c;
                  req_push <= sel_push_c;
                  if (illegal_c) begin
                     // Rejected ops skip memory and answer straight away.
                     state  <= RESP;
                     err    <= 1'b1;
                     a_done <= (gnt_idx_c == REQ_A);
                     b_done <= (gnt_idx_c == REQ_B);
                  end else begin
                     state    <= MEM;
                     mem_we   <= sel_push_c;
                     mem_re   <= ~sel_push_c;
                     mem_addr <= sel_push_c ? sp_out : sp_dec_c;
                     if (sel_push_c)
                        mem_wdata <= sel_wdata_c;
                  end
               end
            end
            MEM: begin
               if (mem_ack) begin
                  state  <= RESP;
                  mem_we <= 1'b0;
                  mem_re <= 1'b0;
                  err    <= 1'b0;
                  a_done <= (req_id == REQ_A);
                  b_done <= (req_id == REQ_B);
                  if (req_push) begin
                     sp_out <= sp_inc_c;
                     full   <= (sp_inc_c == SP_FULL);
                     empty  <= 1'b0;
                  end else begin
                     sp_out <= sp_dec_c;
                     rdata  <= mem_rdata;
                     full   <= 1'b0;
                     empty  <= (sp_dec_c == SP_EMPTY);
                  end
               end
            end
            RESP: begin
               state  <= IDLE;
               a_done <= 1'b0;
               b_done <= 1'b0;
               err    <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_stack_ctrl.sv
// Self-checking bench for stack_ctrl: vector table plus hand-written
// sequences for arbitration, overflow and mid-operation reset.
module tb_stack_ctrl;
   import stack_pkg::*;

   typedef struct {
      logic        req;
      logic        push;
      logic [31:0] wdata;
      int          dly;
      logic        err;
      logic [31:0] rdata;
      logic [31:0] sp;
      logic        full;
      logic        empty;
      logic [31:0] addr;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        a_valid = 1'b0, a_push = 1'b0, b_valid = 1'b0, b_push = 1'b0;
   logic [31:0] a_wdata = '0, b_wdata = '0;
   logic        a_done, b_done, err, mem_we, mem_re, full, empty, mem_ack;
   logic [31:0] rdata, mem_addr, mem_wdata, sp_out;
   logic [31:0] mem_rdata = '0;
   logic        resp_ack = 1'b0, ack_force = 1'b0;

   int n_vec = 0, n_miss = 0;
   int ack_dly = 1, cnt = 0;
   int we_cycles = 0, re_cycles = 0, unsteady = 0, bad_addr = 0;
   logic        p_on = 1'b0, p_we = 1'b0, p_re = 1'b0;
   logic [31:0] p_addr = '0, p_wdata = '0;
   logic [31:0] mem_arr [64];
   logic [31:0] wr_log [$];
   vec_t        exp_q [$];
   vec_t        tbl [9];

   assign mem_ack = resp_ack | ack_force;

   always #5 clk = ~clk;

   stack_ctrl dut (
      .clk(clk), .rst(rst),
      .a_valid(a_valid), .a_push(a_push), .a_wdata(a_wdata), .a_done(a_done),
      .b_valid(b_valid), .b_push(b_push), .b_wdata(b_wdata), .b_done(b_done),
      .rdata(rdata), .err(err),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .sp_out(sp_out), .full(full), .empty(empty)
   );

   // Memory responder: acks after ack_dly strobe cycles and watches strobe stability.
   always @(negedge clk) begin
      logic [31:0] idx;
      if (mem_we) we_cycles++;
      if (mem_re) re_cycles++;
      if ((mem_we || mem_re) && p_on &&
          (mem_addr !== p_addr || mem_we !== p_we || mem_re !== p_re || mem_wdata !== p_wdata))
         unsteady++;
      p_on = mem_we || mem_re; p_addr = mem_addr; p_we = mem_we; p_re = mem_re; p_wdata = mem_wdata;
      if (rst || !(mem_we || mem_re)) begin
         cnt = 0;
         resp_ack = 1'b0;
      end else begin
         cnt++;
         if (cnt >= ack_dly) begin
            resp_ack = 1'b1;
            idx = (mem_addr - 32'd512) >> 2;
            if (mem_addr < 32'd512 || mem_addr > 32'd764 || mem_addr[1:0] != 2'b00)
               bad_addr++;
            else if (mem_we) begin
               mem_arr[idx[5:0]] = mem_wdata;
               wr_log.push_back(mem_addr);
            end else
               mem_rdata = mem_arr[idx[5:0]];
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      a_valid = 1'b0; b_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   // Issue one op from the IDLE negedge, then compare the response against the scoreboard.
   task automatic run_op(input vec_t v);
      vec_t        e;
      int          lat = 0, we0 = we_cycles, re0 = re_cycles;
      logic        got = 1'b0;
      logic [31:0] seen_addr = '0;
      exp_q.push_back(v);
      ack_dly = v.dly;
      if (v.req == REQ_A) begin a_valid = 1'b1; a_push = v.push; a_wdata = v.wdata; end
      else                begin b_valid = 1'b1; b_push = v.push; b_wdata = v.wdata; end
      while (!got && lat < 40) begin
         @(negedge clk);
         lat++;
         if (mem_we || mem_re) seen_addr = mem_addr;
         if (a_done || b_done) got = 1'b1;
      end
      a_valid = 1'b0; b_valid = 1'b0;
      e = exp_q.pop_front();
      if (!got) chk("done_timeout", 32'(got), 32'd1);
      else begin
         chk("done_sel", 32'({a_done, b_done}), (e.req == REQ_B) ? 32'd1 : 32'd2);
         chk("err", 32'(err), 32'(e.err));
         chk("rdata", rdata, e.rdata);
         chk("sp_out", sp_out, e.sp);
         chk("full", 32'(full), 32'(e.full));
         chk("empty", 32'(empty), 32'(e.empty));
         chk("latency", 32'(lat), e.err ? 32'd1 : 32'(e.dly + 1));
         chk("we_cycles", 32'(we_cycles - we0), (!e.err && e.push) ? 32'(e.dly) : 32'd0);
         chk("re_cycles", 32'(re_cycles - re0), (!e.err && !e.push) ? 32'(e.dly) : 32'd0);
         if (!e.err) chk("mem_addr", seen_addr, e.addr);
      end
      @(negedge clk);
      chk("done_one_cycle", 32'(a_done | b_done), 32'd0);
   endtask

   initial begin
      int   n;
      logic ord [4];
      logic got;
      for (int i = 0; i < 64; i++) mem_arr[i] = '0;

      tbl[0] = '{REQ_A, 1'b1, 32'hDEADBEEF, 1, 1'b0, 32'h0,        32'd516, 1'b0, 1'b0, 32'd512};
      tbl[1] = '{REQ_A, 1'b0, 32'h0,        1, 1'b0, 32'hDEADBEEF, 32'd512, 1'b0, 1'b1, 32'd512};
      tbl[2] = '{REQ_B, 1'b0, 32'h0,        1, 1'b1, 32'hDEADBEEF, 32'd512, 1'b0, 1'b1, 32'd0};
      tbl[3] = '{REQ_B, 1'b1, 32'h12345678, 2, 1'b0, 32'hDEADBEEF, 32'd516, 1'b0, 1'b0, 32'd512};
      tbl[4] = '{REQ_A, 1'b1, 32'hCAFEF00D, 3, 1'b0, 32'hDEADBEEF, 32'd520, 1'b0, 1'b0, 32'd516};
      tbl[5] = '{REQ_B, 1'b0, 32'h0,        1, 1'b0, 32'hCAFEF00D, 32'd516, 1'b0, 1'b0, 32'd516};
      tbl[6] = '{REQ_A, 1'b0, 32'h0,        2, 1'b0, 32'h12345678, 32'd512, 1'b0, 1'b1, 32'd512};
      tbl[7] = '{REQ_A, 1'b0, 32'h0,        1, 1'b1, 32'h12345678, 32'd512, 1'b0, 1'b1, 32'd0};
      tbl[8] = '{REQ_B, 1'b1, 32'h0,        4, 1'b0, 32'h12345678, 32'd516, 1'b0, 1'b0, 32'd512};

      // Reset values
      @(negedge clk);
      chk("rst_sp", sp_out, 32'd512);
      chk("rst_flags", 32'({empty, full}), 32'd2);
      chk("rst_strobes", 32'({mem_we, mem_re, a_done, b_done, err}), 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 9; i++) run_op(tbl[i]);

      // Fill to capacity, overflow, then pop the top word
      do_reset();
      for (int i = 0; i < 64; i++)
         run_op('{i[0] ? REQ_B : REQ_A, 1'b1, 32'(i), 1, 1'b0, 32'h0,
                  32'(512 + 4 * (i + 1)), (i == 63), 1'b0, 32'(512 + 4 * i)});
      run_op('{REQ_A, 1'b1, 32'hFFFFFFFF, 1, 1'b1, 32'h0, 32'd768, 1'b1, 1'b0, 32'd0});
      run_op('{REQ_B, 1'b0, 32'h0, 1, 1'b0, 32'd63, 32'd764, 1'b0, 1'b0, 32'd764});

      // Both requesters pushing continuously with slow acks
      do_reset();
      wr_log.delete();
      ord = '{REQ_A, REQ_B, REQ_A, REQ_B};
      ack_dly = 3;
      a_push = 1'b1; b_push = 1'b1;
      a_wdata = 32'hA0000000; b_wdata = 32'hB0000000;
      a_valid = 1'b1; b_valid = 1'b1;
      n = 0;
      for (int t = 0; t < 80 && n < 4; t++) begin
         @(negedge clk);
         if (a_done || b_done) begin
            chk("rr_order", 32'(b_done), 32'(ord[n]));
            chk("rr_single_done", 32'(a_done & b_done), 32'd0);
            chk("rr_err", 32'(err), 32'd0);
            chk("rr_sp", sp_out, 32'(512 + 4 * (n + 1)));
            if (a_done) begin
               if (a_wdata == 32'hA0000000) a_wdata = 32'hA0000001; else a_valid = 1'b0;
            end else begin
               if (b_wdata == 32'hB0000000) b_wdata = 32'hB0000001; else b_valid = 1'b0;
            end
            n++;
         end
      end
      a_valid = 1'b0; b_valid = 1'b0;
      chk("rr_count", 32'(n), 32'd4);
      chk("rr_writes", 32'(wr_log.size()), 32'd4);
      for (int k = 0; k < 4 && k < wr_log.size(); k++)
         chk("rr_wr_addr", wr_log[k], 32'(512 + 4 * k));
      chk("rr_data0", mem_arr[0], 32'hA0000000);
      chk("rr_data1", mem_arr[1], 32'hB0000000);
      chk("rr_data2", mem_arr[2], 32'hA0000001);
      chk("rr_data3", mem_arr[3], 32'hB0000001);
      @(negedge clk);

      // Reset during MEM of a push, then a stray ack while idle
      do_reset();
      ack_dly = 5;
      a_push = 1'b1; a_wdata = 32'h5555AAAA; a_valid = 1'b1;
      got = 1'b0;
      for (int t = 0; t < 6 && !got; t++) begin
         @(negedge clk);
         if (mem_we) got = 1'b1;
      end
      chk("mid_we_seen", 32'(got), 32'd1);
      #1 rst = 1'b1;
      #1;
      chk("mid_async_we", 32'({mem_we, mem_re}), 32'd0);
      chk("mid_sp", sp_out, 32'd512);
      chk("mid_mem_addr", mem_addr, 32'd0);
      chk("mid_done", 32'({a_done, b_done}), 32'd0);
      a_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      ack_force = 1'b1;
      @(negedge clk);
      ack_force = 1'b0;
      chk("stray_ack_done", 32'({a_done, b_done, err}), 32'd0);
      @(negedge clk);
      chk("stray_ack_sp", sp_out, 32'd512);
      chk("stray_ack_empty", 32'(empty), 32'd1);
      run_op('{REQ_A, 1'b1, 32'h00000077, 1, 1'b0, 32'h0, 32'd516, 1'b0, 1'b0, 32'd512});

      chk("strobe_steady", 32'(unsteady), 32'd0);
      chk("addr_in_range", 32'(bad_addr), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/stack_ctrl.md
# stack_ctrl

Stack controller owning the stack pointer and all stack memory traffic. Two requesters share one stack: the control unit (CALL/RET return addresses) and the execute stage (PUSH/POP of registers). Round-robin arbitration picks a requester, a small FSM sequences one data-memory access per operation, and the block updates SP, full/empty flags and error reporting. It replaces free-running SP arithmetic with a handshaken, bounds-checked stack.

## Interface
- STACK_BASE, 512: byte address of the lowest stack word; also the SP reset value.
- STACK_DEPTH, 64: capacity in 32-bit words; legal word addresses are STACK_BASE .. STACK_BASE+4*(STACK_DEPTH-1), i.e. 512..764.
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- a_valid  in  1  requester A (control unit) has an operation pending; held until a_done.
- a_push  in  1  A operation type: 1 push, 0 pop.
- a_wdata  in  32  A push data.
- a_done  out  1  one-cycle completion pulse to A.
- b_valid, b_push, b_wdata, b_done: same as A, for requester B (execute stage).
- rdata  out  32  pop result; valid in the cycle where a_done or b_done is high.
- err  out  1  high with a_done/b_done when the operation was rejected (push when full, pop when empty).
- mem_addr  out  32  data-memory byte address.
- mem_wdata  out  32  data-memory write data.
- mem_we  out  1  memory write strobe.
- mem_re  out  1  memory read strobe.
- mem_rdata  in  32  memory read data, valid with mem_ack.
- mem_ack  in  1  memory completion; arrives 1 or more cycles after a strobe rises.
- sp_out  out  32  current stack pointer (next free word address).
- full  out  1  sp_out == STACK_BASE + 4*STACK_DEPTH.
- empty  out  1  sp_out == STACK_BASE.

## Operation
- Reset values: sp_out=512, empty=1, full=0, all strobes, done pulses and err at 0, rdata=0, mem_addr=0, mem_wdata=0, FSM in IDLE, round-robin pointer favouring A.
- Push semantics are post-increment: write at SP, then SP += 4. Pop semantics are pre-decrement: read at SP-4, then SP -= 4. SP never wraps.
- FSM states:
  - IDLE: if any valid is high, the arbiter grants one requester. The grant, op type and wdata are latched on the edge.
  - If the granted op is legal, IDLE goes to MEM. If it is illegal (push && full, or pop && empty), IDLE goes to RESP with err=1, no memory access, and SP unchanged.
  - MEM: mem_we=push and mem_re=pop are held steady. mem_addr is SP for a push and SP-4 for a pop. On the edge with mem_ack=1: SP is updated, pop data is latched into rdata, and the FSM goes to RESP.
  - RESP: the granted done pulse is high for exactly one cycle, err and rdata are valid, and the FSM returns to IDLE.
- Arbitration is round-robin:
  - The pointer toggles to the other requester after each grant, whether the grant completed or errored.
  - When both requesters are valid, the pointed requester wins. When only one is valid, it wins regardless of the pointer.
- A requester must drop valid on the edge after its done pulse. A valid still high in the IDLE cycle after RESP is treated as a new request.
- rdata holds its last value after a push or an error.

## Timing
- Minimum legal latency is 2 cycles. Example: valid is sampled at edge 0, so MEM occupies cycle 1; mem_ack in cycle 1 makes RESP/done occur in cycle 2.
- Error latency is 1 cycle: done with err=1 in the cycle after the sampling edge.
- sp_out, full and empty change on the mem_ack edge, so they are already updated in the RESP cycle.
- Throughput is at most one operation per 3 cycles, because IDLE is mandatory between operations.
- Reset asserted mid-operation clears everything to reset values immediately. In-flight memory strobes drop asynchronously, and the pending request is lost without a done pulse.
- mem_ack outside the MEM state is ignored.

## Structure
- Shared package stack_pkg holds:
  - STACK_BASE, STACK_DEPTH and WORD_BYTES=4.
  - The FSM state encoding: IDLE=2'd0, MEM=2'd1, RESP=2'd2.
  - The requester IDs: REQ_A=1'b0, REQ_B=1'b1.
- One sub-module: rr_arb2, a two-input round-robin arbiter that owns the pointer flop and produces the grant index and grant valid.
- SP register, FSM, request latch and bounds logic live in stack_ctrl.

## Test plan
- Reset, then an A push of 0xDEADBEEF with 1-cycle ack: mem_we at addr 512; a_done in cycle 2 with err=0; sp_out=516; empty=0.
- A pop immediately after that: mem_re at addr 512 with mem_rdata=0xDEADBEEF; rdata=0xDEADBEEF; sp_out=512; empty=1.
- Pop on an empty stack from B: b_done one cycle after the sampling edge with err=1; mem_re never asserted; sp_out stays 512.
- 64 pushes with data 0..63, then a 65th push: the 64th push writes addr 764 and sp_out=768 with full=1; the 65th returns err=1 with no mem_we.
- A and B both valid continuously, each pushing: grants alternate A,B,A,B; writes land at 512, 516, 520, 524; mem_ack delayed 3 cycles holds MEM and the strobe steady.
- Reset asserted during MEM of a push: mem_we drops without waiting for a clock; no done pulse; sp_out=512. A later mem_ack is ignored.
